// File: rtl/gaussian3x3_filter.sv
// Streaming 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1] / 16) over a raster-order
// ROWS x COLS patch, emitting the (ROWS-2) x (COLS-2) valid region with TLAST.
module gaussian3x3_filter #(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int ROWS             = 48,
    parameter int COLS             = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
    input  logic                       pixel_in_TVALID,
    output logic                       pixel_in_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
    output logic                       pixel_out_TVALID,
    input  logic                       pixel_out_TREADY,
    output logic                       pixel_out_TLAST
);

    localparam int W   = PIXEL_BIT_WIDTH;
    localparam int AW  = PIXEL_BIT_WIDTH + 4;
    localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;

    // Handshake: a beat moves when TVALID & TREADY are both high at a rising
    // edge; the sender keeps TDATA/TVALID (and TLAST) stable until then.
    logic [IMG_ROW_BITWIDTH-1:0] row;
    logic [IMG_COL_BITWIDTH-1:0] col;
    logic [CIW-1:0]              col_idx;

    logic signed [W-1:0]  lb0 [COLS];
    logic signed [W-1:0]  lb1 [COLS];
    logic signed [W-1:0]  win [3][3];
    logic signed [W-1:0]  new_col [3];
    logic signed [AW-1:0] row_sum [3];
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] rounded;
    logic        [W-1:0]  result;

    logic accept;
    logic last_col;
    logic last_row;
    logic produce;
    logic frame_end;

    assign pixel_in_TREADY = ~pixel_out_TVALID | pixel_out_TREADY;
    assign accept          = pixel_in_TVALID & pixel_in_TREADY;
    assign col_idx         = col[CIW-1:0];
    assign last_col        = (col == IMG_COL_BITWIDTH'(COLS - 1));
    assign last_row        = (row == IMG_ROW_BITWIDTH'(ROWS - 1));
    assign frame_end       = last_row & last_col;
    assign produce         = accept & (row >= IMG_ROW_BITWIDTH'(2))
                                    & (col >= IMG_COL_BITWIDTH'(2));

    // Column entering the window: index 0 is row r-2, index 2 the live pixel.
    always_comb begin
        new_col[0] = lb1[col_idx];
        new_col[1] = lb0[col_idx];
        new_col[2] = pixel_in_TDATA;
    end

    // The kernel is separable: each row is [1 2 1], rows weighted [1 2 1].
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            row_sum[i] = AW'(win[i][1]) + (AW'(win[i][2]) <<< 1) + AW'(new_col[i]);
        end
        sum     = row_sum[0] + (row_sum[1] <<< 1) + row_sum[2];
        rounded = sum + AW'(8);
        result  = W'(rounded >>> 4);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers carry no reset: rows 0-1 never produce output.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_idx] <= lb0[col_idx];
            lb0[col_idx] <= pixel_in_TDATA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
                win[i][2] <= new_col[i];
            end
        end
    end

    // A producing accept can only happen when the register is free or being
    // drained this cycle, so loading never overwrites an unsent result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_out_TDATA  <= '0;
            pixel_out_TVALID <= 1'b0;
            pixel_out_TLAST  <= 1'b0;
        end else if (produce) begin
            pixel_out_TDATA  <= result;
            pixel_out_TVALID <= 1'b1;
            pixel_out_TLAST  <= frame_end;
        end else if (pixel_out_TVALID && pixel_out_TREADY) begin
            pixel_out_TVALID <= 1'b0;
            pixel_out_TLAST  <= 1'b0;
        end
    end

endmodule
